// File: rtl/puf_eval_pkg.sv
// Shared types and helpers for the TERO PUF evaluation sequencer.
// Holds the FSM state encoding and a clog2 helper that never returns 0.
package puf_eval_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_EVAL     = 3'd2,
        ST_STORE    = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_SELECT   = 3'd5,
        ST_DONE     = 3'd6
    } puf_state_t;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/puf_loop_counter.sv
// Loop position counter: tracks position p and the selected loop index
// (p + challenge) mod NUM_LOOPS, valid for non-power-of-two loop counts.
module puf_loop_counter
    import puf_eval_pkg::*;
#(
    parameter int NUM_LOOPS      = 8,
    parameter int CHALLENGE_BITS = 4,
    localparam int SEL_W         = clog2_min1(NUM_LOOPS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_load,
    input  logic [CHALLENGE_BITS-1:0] i_challenge,
    input  logic                      i_advance,
    output logic [SEL_W-1:0]          o_select,
    output logic                      o_last
);

    localparam int MOD_W = (CHALLENGE_BITS > SEL_W + 1) ? CHALLENGE_BITS : SEL_W + 1;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_LOOPS - 1);

    logic [MOD_W-1:0] w_ch_ext;
    logic [MOD_W-1:0] w_ch_mod;
    logic [SEL_W-1:0] r_pos;
    logic [SEL_W-1:0] r_sel;

    // The modulo is taken once at load; afterwards the index just wraps.
    assign w_ch_ext = MOD_W'(i_challenge);
    assign w_ch_mod = w_ch_ext % MOD_W'(NUM_LOOPS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos <= '0;
            r_sel <= '0;
        end else if (i_load) begin
            r_pos <= '0;
            r_sel <= w_ch_mod[SEL_W-1:0];
        end else if (i_advance) begin
            r_pos <= r_pos + SEL_W'(1);
            r_sel <= (r_sel == LAST_IDX) ? '0 : r_sel + SEL_W'(1);
        end
    end

    assign o_select = r_sel;
    assign o_last   = (r_pos == LAST_IDX);

endmodule

// File: rtl/puf_eval_sequencer.sv
// Sequencer that resets, enables and repeatedly evaluates TERO loops, then
// hands each loop's averaged response off through a next_enable handshake.
module puf_eval_sequencer
    import puf_eval_pkg::*;
#(
    parameter int NUM_LOOPS        = 8,
    parameter int CHALLENGE_BITS   = 4,
    parameter int EVAL_TIME_BITS   = 16,
    parameter int REPETITIONS_BITS = 16,
    parameter int SETTLE_CYCLES    = 2,
    localparam int SEL_W           = clog2_min1(NUM_LOOPS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        mode_single,
    input  logic [CHALLENGE_BITS-1:0]   challenge,
    input  logic [EVAL_TIME_BITS-1:0]   eval_time,
    input  logic [REPETITIONS_BITS-1:0] repetitions,
    input  logic                        next_enable,
    output logic                        reset_puf,
    output logic                        enable_puf,
    output logic [SEL_W-1:0]            select_puf,
    output logic                        rep_strobe,
    output logic                        store_response_puf,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output puf_state_t                  o_state
);

    // Handshake: in WAIT_ACK the downstream averager raises next_enable when
    // it can take the next loop; the first cycle it is high ends WAIT_ACK.

    puf_state_t                  r_state;
    puf_state_t                  w_next;
    logic                        r_mode_single_q;
    logic [EVAL_TIME_BITS-1:0]   r_eval_time_q;
    logic [EVAL_TIME_BITS-1:0]   r_eval_cnt;
    logic [REPETITIONS_BITS-1:0] r_reps_q;
    logic [REPETITIONS_BITS-1:0] r_rep_cnt;
    logic [7:0]                  r_settle_cnt;
    logic                        r_aborted;

    logic w_busy;
    logic w_abort_hit;
    logic w_settle_last;
    logic w_eval_last;
    logic w_rep_last;
    logic w_loop_last;
    logic w_load;
    logic w_advance;

    assign w_busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_abort_hit   = w_busy && abort;
    assign w_settle_last = (r_settle_cnt == 8'(SETTLE_CYCLES - 1));
    // Counters run 0..max-1, so the latched maximum is reached without wrap.
    assign w_eval_last   = (r_eval_cnt == r_eval_time_q - EVAL_TIME_BITS'(1));
    assign w_rep_last    = (r_rep_cnt == r_reps_q - REPETITIONS_BITS'(1));
    assign w_load        = (r_state == ST_IDLE) && start;
    assign w_advance     = (r_state == ST_SELECT) && (w_next == ST_INIT);

    puf_loop_counter #(
        .NUM_LOOPS      (NUM_LOOPS),
        .CHALLENGE_BITS (CHALLENGE_BITS)
    ) u_loop_counter (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_challenge (challenge),
        .i_advance   (w_advance),
        .o_select    (select_puf),
        .o_last      (w_loop_last)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (start) w_next = ST_INIT;
            ST_INIT:     if (w_settle_last) w_next = ST_EVAL;
            ST_EVAL:     if (w_eval_last) w_next = w_rep_last ? ST_STORE : ST_INIT;
            ST_STORE:    w_next = ST_WAIT_ACK;
            ST_WAIT_ACK: if (next_enable) w_next = ST_SELECT;
            ST_SELECT:   w_next = (r_mode_single_q || w_loop_last) ? ST_DONE : ST_INIT;
            ST_DONE:     if (!start) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
        if (w_abort_hit) w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode_single_q <= 1'b0;
            r_eval_time_q   <= EVAL_TIME_BITS'(1);
            r_reps_q        <= REPETITIONS_BITS'(1);
            r_eval_cnt      <= '0;
            r_rep_cnt       <= '0;
            r_settle_cnt    <= '0;
            r_aborted       <= 1'b0;
        end else begin
            r_aborted <= w_abort_hit;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode_single_q <= mode_single;
                        r_eval_time_q   <= (eval_time == '0) ? EVAL_TIME_BITS'(1) : eval_time;
                        r_reps_q        <= (repetitions == '0) ? REPETITIONS_BITS'(1) : repetitions;
                        r_eval_cnt      <= '0;
                        r_rep_cnt       <= '0;
                        r_settle_cnt    <= '0;
                    end
                end
                ST_INIT: begin
                    r_settle_cnt <= w_settle_last ? 8'd0 : r_settle_cnt + 8'd1;
                    r_eval_cnt   <= '0;
                end
                ST_EVAL: begin
                    if (w_eval_last) begin
                        r_eval_cnt <= '0;
                        r_rep_cnt  <= w_rep_last ? '0 : r_rep_cnt + REPETITIONS_BITS'(1);
                    end else begin
                        r_eval_cnt <= r_eval_cnt + EVAL_TIME_BITS'(1);
                    end
                end
                ST_SELECT: begin
                    r_rep_cnt    <= '0;
                    r_settle_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign reset_puf          = (r_state == ST_INIT);
    assign enable_puf         = (r_state == ST_EVAL);
    assign rep_strobe         = (r_state == ST_EVAL) && w_eval_last;
    assign store_response_puf = (r_state == ST_STORE);
    assign busy               = w_busy;
    assign done               = (r_state == ST_DONE);
    assign aborted            = r_aborted;
    assign o_state            = r_state;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Bench for puf_eval_sequencer: a 4-loop and a 5-loop instance share stimulus;
// a run table covers sweep/single/zero-config, then handshake, abort and reset.
module tb_puf_eval_sequencer;
    import puf_eval_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        mode_single;
    logic [3:0]  challenge;
    logic [15:0] eval_time;
    logic [15:0] repetitions;
    logic        next_enable;

    logic       reset_puf_a, enable_puf_a, rep_strobe_a, store_a, busy_a, done_a, aborted_a;
    logic [1:0] select_a;
    puf_state_t st_a;
    logic       reset_puf_b, enable_puf_b, rep_strobe_b, store_b, busy_b, done_b, aborted_b;
    logic [2:0] select_b;
    puf_state_t st_b;

    puf_eval_sequencer #(.NUM_LOOPS(4), .SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode_single(mode_single),
        .challenge(challenge), .eval_time(eval_time), .repetitions(repetitions),
        .next_enable(next_enable), .reset_puf(reset_puf_a), .enable_puf(enable_puf_a),
        .select_puf(select_a), .rep_strobe(rep_strobe_a), .store_response_puf(store_a),
        .busy(busy_a), .done(done_a), .aborted(aborted_a), .o_state(st_a)
    );

    puf_eval_sequencer #(.NUM_LOOPS(5), .SETTLE_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode_single(mode_single),
        .challenge(challenge), .eval_time(eval_time), .repetitions(repetitions),
        .next_enable(next_enable), .reset_puf(reset_puf_b), .enable_puf(enable_puf_b),
        .select_puf(select_b), .rep_strobe(rep_strobe_b), .store_response_puf(store_b),
        .busy(busy_b), .done(done_b), .aborted(aborted_b), .o_state(st_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / monitor ----------------
    int n_pass = 0;
    int n_total = 0;
    logic mon_en = 1'b0;
    logic mon_clr = 1'b0;
    int strobes_a, stores_a, en_a, ab_a, init_cyc_a, done_cyc_a;
    int strobes_b, stores_b, en_b, ab_b, init_cyc_b, done_cyc_b;
    logic [3:0] exp_q[$];
    int sel_q_a[$];
    int sel_q_b[$];

    always @(negedge clk) begin
        if (mon_clr) begin
            strobes_a = 0; stores_a = 0; en_a = 0; ab_a = 0; init_cyc_a = -1; done_cyc_a = -1;
            strobes_b = 0; stores_b = 0; en_b = 0; ab_b = 0; init_cyc_b = -1; done_cyc_b = -1;
            sel_q_a.delete();
            sel_q_b.delete();
        end else if (mon_en) begin
            if (st_a == ST_INIT && init_cyc_a < 0) init_cyc_a = cyc;
            if (done_a && done_cyc_a < 0) done_cyc_a = cyc;
            if (rep_strobe_a) strobes_a++;
            if (enable_puf_a) en_a++;
            if (aborted_a) ab_a++;
            if (store_a) begin stores_a++; sel_q_a.push_back(int'(select_a)); end
            if (st_b == ST_INIT && init_cyc_b < 0) init_cyc_b = cyc;
            if (done_b && done_cyc_b < 0) done_cyc_b = cyc;
            if (rep_strobe_b) strobes_b++;
            if (enable_puf_b) en_b++;
            if (aborted_b) ab_b++;
            if (store_b) begin stores_b++; sel_q_b.push_back(int'(select_b)); end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int outs_a();
        return int'({reset_puf_a, enable_puf_a, rep_strobe_a, store_a, busy_a, done_a,
                     aborted_a, select_a, st_a});
    endfunction

    function automatic int outs_b();
        return int'({reset_puf_b, enable_puf_b, rep_strobe_b, store_b, busy_b, done_b,
                     aborted_b, select_b, st_b});
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_monitor();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic wait_state_a(input puf_state_t s, input string nm);
        bit ok;
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (st_a == s) begin ok = 1; break; end
        end
        check(nm, int'(ok), 1);
    endtask

    typedef struct {
        logic [3:0]  chal;
        logic        mode;
        logic [15:0] et;
        logic [15:0] reps;
        int          n_a;
        logic [19:0] ord_a;
        int          strobes_a;
        int          en_a;
        int          cyc_a;
        int          n_b;
        logic [19:0] ord_b;
        int          strobes_b;
        int          en_b;
        int          cyc_b;
    } run_t;

    run_t runs[4];

    task automatic run_cfg(input int idx);
        run_t r;
        bit ok;
        logic [19:0] ord;
        r = runs[idx];
        clear_monitor();
        challenge = r.chal; mode_single = r.mode; eval_time = r.et; repetitions = r.reps;
        next_enable = 1'b1; start = 1'b1; mon_en = 1'b1;
        ok = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (done_a && done_b) begin ok = 1; break; end
        end
        check($sformatf("run%0d_done", idx), int'(ok), 1);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        check($sformatf("run%0d_idle_a", idx), int'(st_a), int'(ST_IDLE));
        check($sformatf("run%0d_idle_b", idx), int'(st_b), int'(ST_IDLE));
        check($sformatf("run%0d_strobes_a", idx), strobes_a, r.strobes_a);
        check($sformatf("run%0d_strobes_b", idx), strobes_b, r.strobes_b);
        check($sformatf("run%0d_stores_a", idx), stores_a, r.n_a);
        check($sformatf("run%0d_stores_b", idx), stores_b, r.n_b);
        check($sformatf("run%0d_en_a", idx), en_a, r.en_a);
        check($sformatf("run%0d_en_b", idx), en_b, r.en_b);
        check($sformatf("run%0d_latency_a", idx), done_cyc_a - init_cyc_a, r.cyc_a);
        check($sformatf("run%0d_latency_b", idx), done_cyc_b - init_cyc_b, r.cyc_b);
        exp_q.delete();
        ord = r.ord_a;
        for (int i = 0; i < r.n_a; i++) exp_q.push_back(ord[4*i +: 4]);
        for (int i = 0; i < r.n_a && i < sel_q_a.size(); i++)
            check($sformatf("run%0d_sel_a[%0d]", idx, i), sel_q_a[i], int'(exp_q[i]));
        exp_q.delete();
        ord = r.ord_b;
        for (int i = 0; i < r.n_b; i++) exp_q.push_back(ord[4*i +: 4]);
        for (int i = 0; i < r.n_b && i < sel_q_b.size(); i++)
            check($sformatf("run%0d_sel_b[%0d]", idx, i), sel_q_b[i], int'(exp_q[i]));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit ok;
        int sel0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode_single = 1'b0;
        challenge = '0; eval_time = '0; repetitions = '0; next_enable = 1'b1;

        // chal, mode, et, reps | a: n, order, strobes, en, latency | b: same
        runs[0] = '{4'd1,  1'b0, 16'd3, 16'd2, 4, 20'h00321, 8, 24, 52, 5, 20'h04321, 10, 30, 65};
        runs[1] = '{4'd13, 1'b0, 16'd1, 16'd1, 4, 20'h00321, 4, 4, 24, 5, 20'h21043, 5, 5, 30};
        runs[2] = '{4'd6,  1'b1, 16'd0, 16'd0, 1, 20'h00002, 1, 1, 6, 1, 20'h00001, 1, 1, 6};
        runs[3] = '{4'd15, 1'b1, 16'd4, 16'd3, 1, 20'h00003, 3, 12, 21, 1, 20'h00000, 3, 12, 21};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs_a", outs_a(), 0);
        check("reset_outs_b", outs_b(), 0);
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 4; i++) run_cfg(i);

        // abort in IDLE has no effect
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("idle_abort_state", int'(st_a), int'(ST_IDLE));
        check("idle_abort_flag", int'(aborted_a), 0);

        // handshake: next_enable low holds WAIT_ACK
        challenge = 4'd1; mode_single = 1'b1; eval_time = 16'd1; repetitions = 16'd1;
        next_enable = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (store_a) begin ok = 1; break; end
        end
        check("hs_store_seen", int'(ok), 1);
        sel0 = int'(select_a);
        check("hs_sel", sel0, 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("hs_wait_state[%0d]", c), int'(st_a), int'(ST_WAIT_ACK));
            check($sformatf("hs_wait_sel[%0d]", c), int'(select_a), 1);
        end
        @(posedge clk); #1 next_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hs_select_state", int'(st_a), int'(ST_SELECT));
        @(posedge clk);
        @(negedge clk);
        check("hs_done", int'(done_a), 1);

        // abort during the second EVAL
        wait_state_a(ST_IDLE, "ab_pre_idle");
        clear_monitor();
        challenge = 4'd0; mode_single = 1'b0; eval_time = 16'd3; repetitions = 16'd2;
        next_enable = 1'b1; start = 1'b1; mon_en = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rep_strobe_a) begin ok = 1; break; end
        end
        check("ab_first_strobe", int'(ok), 1);
        wait_state_a(ST_EVAL, "ab_second_eval");
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("ab_state", int'(st_a), int'(ST_IDLE));
        check("ab_pulse", int'(aborted_a), 1);
        check("ab_puf_ctrl", int'({reset_puf_a, enable_puf_a, busy_a}), 0);
        @(negedge clk);
        check("ab_pulse_end", int'(aborted_a), 0);
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        check("ab_pulse_count", ab_a, 1);
        check("ab_no_done", done_cyc_a, -1);

        // a normal run after the abort
        run_cfg(0);

        // abort beats next_enable in WAIT_ACK
        challenge = 4'd2; mode_single = 1'b1; eval_time = 16'd1; repetitions = 16'd1;
        next_enable = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_state_a(ST_WAIT_ACK, "abne_wait");
        @(posedge clk); #1 abort = 1'b1; next_enable = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abne_state", int'(st_a), int'(ST_IDLE));
        check("abne_pulse", int'(aborted_a), 1);

        // reset during INIT, start held through reset
        start = 1'b1;
        wait_state_a(ST_INIT, "rst_init");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_outs_a", outs_a(), 0);
        check("rst_outs_b", outs_b(), 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_restart_a", int'(st_a), int'(ST_INIT));
        @(posedge clk); #1 start = 1'b0; abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("rst_cleanup", int'(st_a), int'(ST_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
